// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB full-speed receive datapath:
// bit-timer state encoding and default timing constants.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } rx_timer_state_t;

    localparam int CLKS_PER_BIT_DEF  = 8;
    localparam int SAMPLE_PHASE_DEF  = 3;
    localparam int BITS_PER_BYTE_DEF = 8;

endpackage

// File: rtl/rx_phase_counter.sv
// Wrapping phase counter (0..MODULUS-1) with synchronous clear,
// count enable and a load-zero input used to resynchronise on line edges.
module rx_phase_counter #(
    parameter int MODULUS = 8,
    parameter int W       = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         load_zero_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear and resync both force zero; otherwise advance and wrap at LAST.
    always_comb begin
        count_d = count_q;
        if (clr_i || load_zero_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    // Phase register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/usb_rx_bit_timer.sv
// Receive bit scheduler: recovers bit timing from NRZI edges, strobes
// shift_enable once per bit, drops stuffed bits and counts bytes.
// Optional stuffing-violation check enabled by USB_RX_STUFF_CHECK_EN.
// dbg_state exposes the FSM state for observation.
module usb_rx_bit_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
    parameter int SAMPLE_PHASE  = SAMPLE_PHASE_DEF,
    parameter int BITS_PER_BYTE = BITS_PER_BYTE_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               d_edge,
    input  logic                               shift_stop,
    output logic                               shift_enable,
    output logic                               byte_received,
    output logic [$clog2(BITS_PER_BYTE+1)-1:0] bit_count,
    output logic                               stuff_err,
    output logic [1:0]                         dbg_state
);

    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(BITS_PER_BYTE + 1);
    localparam logic [PW-1:0] SAMPLE_C   = PW'(SAMPLE_PHASE);
    localparam logic [CW-1:0] LAST_BIT_C = CW'(BITS_PER_BYTE - 1);

    rx_timer_state_t state_q;
    rx_timer_state_t state_d;
    logic [PW-1:0]   phase;
    logic [CW-1:0]   bit_count_q;
    logic [CW-1:0]   bit_count_d;
    logic            byte_q;
    logic            byte_d;

    // Next-state logic; dropping enable always returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = SYNC;
            SYNC:    if (d_edge) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Phase is held at zero outside RUN, so RUN always starts at phase 0
    // the cycle after the synchronising edge.
    rx_phase_counter #(
        .MODULUS (CLKS_PER_BIT),
        .W       (PW)
    ) u_phase (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (!enable || (state_q != RUN)),
        .en_i        (state_q == RUN),
        .load_zero_i (d_edge),
        .count_o     (phase)
    );

    // An edge in the sample cycle wins over the strobe.
    assign shift_enable = (state_q == RUN) && (phase == SAMPLE_C) && !d_edge;

    // Count non-stuffed bits; a byte completes when the count wraps.
    always_comb begin
        bit_count_d = bit_count_q;
        byte_d      = 1'b0;
        if (!enable) begin
            bit_count_d = '0;
        end else if (shift_enable && !shift_stop) begin
            if (bit_count_q == LAST_BIT_C) begin
                bit_count_d = '0;
                byte_d      = 1'b1;
            end else begin
                bit_count_d = bit_count_q + CW'(1);
            end
        end
    end

    // Bit counter and byte pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_count_q <= '0;
            byte_q      <= 1'b0;
        end else begin
            bit_count_q <= bit_count_d;
            byte_q      <= byte_d;
        end
    end

`ifdef USB_RX_STUFF_CHECK_EN
    logic edge_seen_q;
    logic edge_seen_d;
    logic stuff_err_q;
    logic stuff_err_d;

    // A stuffed bit is a 0 (a transition); no edge since the last strobe
    // means the unstuffer dropped a 1, which is a violation.
    always_comb begin
        edge_seen_d = edge_seen_q;
        stuff_err_d = stuff_err_q;
        if (!enable) begin
            edge_seen_d = 1'b0;
            stuff_err_d = 1'b0;
        end else begin
            if (shift_enable && shift_stop && !edge_seen_q) begin
                stuff_err_d = 1'b1;
            end
            if (shift_enable) begin
                edge_seen_d = 1'b0;
            end else if (d_edge) begin
                edge_seen_d = 1'b1;
            end
        end
    end

    // Edge tracker and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_seen_q <= 1'b0;
            stuff_err_q <= 1'b0;
        end else begin
            edge_seen_q <= edge_seen_d;
            stuff_err_q <= stuff_err_d;
        end
    end

    assign stuff_err = stuff_err_q;
`else
    assign stuff_err = 1'b0;
`endif

    assign byte_received = byte_q;
    assign bit_count     = bit_count_q;
    assign dbg_state     = state_q;

endmodule

// File: doc/usb_rx_bit_timer.md
# usb_rx_bit_timer

Receive-side bit scheduler for the USB full-speed datapath. It recovers bit timing from NRZI edges (`d_edge`) and issues one-cycle `shift_enable` strobes, one per bit period, to the bit unstuffer and the receive shift register. It drops bits that the unstuffer flags with `shift_stop`, counts the remaining data bits into bytes, and pulses `byte_received` for the receive controller.

## Interface
- `CLKS_PER_BIT`, 8: system clocks per USB bit period; minimum 4.
- `SAMPLE_PHASE`, 3: phase count at which `shift_enable` fires; must be in 1..CLKS_PER_BIT-1.
- `BITS_PER_BYTE`, 8: counted (non-stuffed) bits per byte.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: receive window open, from the receive controller.
- `d_edge` in 1: single-cycle pulse on each NRZI line transition.
- `shift_stop` in 1: from `bit_unstuff`; the current bit is a stuffed bit.
- `shift_enable` out 1: bit strobe to `bit_unstuff` and the shift register.
- `byte_received` out 1: one-cycle pulse after BITS_PER_BYTE counted bits.
- `bit_count` out $clog2(BITS_PER_BYTE+1): counted bits in the current byte.
- `stuff_err` out 1: sticky flag for a stuffing violation (see Configuration).

## Operation
States:
- IDLE: counters held at 0. Go to SYNC when `enable`=1.
- SYNC: wait for the first `d_edge`, then go to RUN. The phase counter loads 0.
- RUN: free-running phase counter 0..CLKS_PER_BIT-1 that wraps to 0.
- From any state, `enable`=0 sends the block to IDLE on the next clock. `bit_count` and the phase counter clear. No `byte_received` is issued for a partial byte.

Phase counter:
- In RUN, any `d_edge` resynchronises it: the next value is 0, regardless of the current value.

Strobe:
- `shift_enable` = (state==RUN) && (phase==SAMPLE_PHASE) && !`d_edge`.
- If `d_edge` arrives in the sample cycle, the edge wins. The strobe is suppressed, and the bit is sampled SAMPLE_PHASE+1 cycles later.

Bit counting:
- On `shift_enable` with `shift_stop`=0, `bit_count` increments.
- On `shift_enable` with `shift_stop`=1, the bit is dropped and `bit_count` is unchanged.
- When the increment reaches BITS_PER_BYTE, `bit_count` wraps to 0 and `byte_received` pulses for one cycle on the next clock.

## Timing
- Reset values: state IDLE; `shift_enable`, `byte_received` and `stuff_err` are 0; `bit_count` is 0; phase is 0.
- The first `shift_enable` is SAMPLE_PHASE+1 cycles after the `d_edge` cycle that caused RUN entry or resync.
- With no further edges, `shift_enable` recurs every CLKS_PER_BIT cycles.
- `byte_received` is asserted in the cycle after the `shift_enable` that completes the byte.
- `shift_stop` is sampled only in `shift_enable` cycles.
- `rst` mid-byte: the block is in IDLE next cycle and all outputs are at reset values.

## Configuration
- `USB_RX_STUFF_CHECK_EN` defined:
  - An `edge_seen` flag records any `d_edge` since the last `shift_enable`.
  - On `shift_enable` with `shift_stop`=1 and `edge_seen`=0, the stuffed bit was a 1, which is a violation.
  - `stuff_err` is set on the next clock.
  - It stays set until `enable`=0 or `rst`.
- Undefined: `stuff_err` is tied to 0 and no `edge_seen` logic exists.

## Structure
- Shared package `usb_rx_pkg`:
  - state enum `rx_timer_state_t` {IDLE, SYNC, RUN};
  - default constants for CLKS_PER_BIT, SAMPLE_PHASE and BITS_PER_BYTE.
- One sub-module, `rx_phase_counter`:
  - a wrapping counter with synchronous clear, count enable and load-zero (resync);
  - instantiated for the phase counter.
- The bit counter is inline logic.

## Test plan
- Reset and idle: `rst`=1 for 2 cycles with `enable`=1 and `d_edge` toggling. All outputs stay 0 and the state stays IDLE.
- Nominal byte: `enable`=1, one `d_edge`, no further edges, `shift_stop`=0. Strobes come 4, 12, 20, … 60 cycles after the edge. `byte_received` pulses at cycle 61 and `bit_count` returns to 0.
- Resync: an edge at phase 6 gives the next strobe 4 cycles later instead of 5. An edge coincident with the phase-3 cycle suppresses that strobe, and a strobe follows 4 cycles later.
- Stuffed bit: `shift_stop`=1 on the 7th strobe. The byte completes on the 9th strobe, and `bit_count` is unchanged across the dropped bit.
- Abort: `enable`=0 after 5 counted bits. No `byte_received`; the next cycle shows IDLE with `bit_count`=0.
- With `USB_RX_STUFF_CHECK_EN`:
  - `shift_stop`=1 with no edge since the prior strobe sets `stuff_err` one cycle later, and it holds until `enable`=0.
  - With an edge in that window, `stuff_err` stays 0.
